cirno9_boot_loader: RTL

Synthesizable boot loader that sits directly upstream of the cirno9 instruction/data SRAM (`u_sram32`). It replaces the simulation-only hex backdoor preload. It receives a framed little-endian byte stream, packs it into 32-bit words and writes them to SRAM from word 0 upward, verifying a checksum at the end. It holds the core in reset until the image is loaded and verified.

---
 rtl/cirno9_boot_pkg.sv | 18 +
 rtl/cirno9_byte_packer.sv | 41 ++++
 rtl/cirno9_boot_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cirno9_boot_pkg.sv
// cirno9_boot_pkg: types and constants for the cirno9 boot loader.
//   boot_state_t   : loader FSM states (LEN, DATA, CSUM, DONE, ERR)
//   BOOT_LEN_BYTES : number of little-endian bytes in the word-count header
//   BOOT_WEM_FULL  : full-word SRAM byte-enable pattern
package cirno9_boot_pkg;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } boot_state_t;

  localparam int         BOOT_LEN_BYTES = 4;
  localparam logic [3:0] BOOT_WEM_FULL  = 4'hF;

endpackage

// File: rtl/cirno9_byte_packer.sv
// cirno9_byte_packer: packs accepted data bytes little-endian into 32-bit words
// and keeps the 8-bit running sum of every data byte.
//   clk, rst   : clock, synchronous active-high reset (counter and sum only)
//   byte_vld   : a data byte is accepted this cycle
//   byte_data  : the accepted byte
//   word_vld   : combinational; this byte completes a word
//   word_data  : combinational; the completed word (valid with word_vld)
//   sum        : running sum of all data bytes accepted since reset
module cirno9_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic        word_vld,
  output logic [31:0] word_data,
  output logic [7:0]  sum
);

  logic [1:0]  cnt_p0;
  logic [31:0] shift_p0;

  // Byte k of a word ends up in bits [8k+7:8k]: bytes enter at the top and
  // shift down, so the 4th byte is combined with the three already held.
  assign word_vld  = byte_vld && (cnt_p0 == 2'd3);
  assign word_data = {byte_data, shift_p0[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= 2'd0;
      sum    <= 8'd0;
    end else if (byte_vld) begin
      cnt_p0 <= cnt_p0 + 2'd1;
      sum    <= sum + byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld) shift_p0 <= {byte_data, shift_p0[31:8]};
  end

endmodule

// File: rtl/cirno9_boot_loader.sv
// cirno9_boot_loader: receives a framed little-endian byte stream
// (4-byte word count N, N*4 data bytes, 1-byte checksum), writes the words to
// SRAM from address 0 upward and releases the CPU reset once the checksum
// matches.
//   clk, rst        : clock, synchronous active-high reset
//   rx_valid/ready  : byte-stream handshake, rx_data is the byte
//   mem_we/addr/... : SRAM write port; held stable while mem_ready is low
//   mem_ready       : SRAM accepts the pending write this cycle
//   cpu_rst_n       : CPU reset, released only after a verified load
//   load_done       : sticky, image loaded and checksum correct
//   load_err        : sticky, length overflow or checksum mismatch
module cirno9_boot_loader
  import cirno9_boot_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wem,
  input  logic              mem_ready,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [32:0] CAP_WORDS = 33'd1 << ADDR_W;

  boot_state_t       state;
  logic [1:0]        len_cnt;
  logic [23:0]       len_p0;
  logic [31:0]       n_next;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   len_last;
  logic              acc;
  logic              last_len_byte;
  logic              byte_vld;
  logic              word_vld;
  logic [31:0]       word_data;
  logic [7:0]        sum;

  // A byte can be taken whenever the loader is still receiving and the write
  // port is free or frees up this same cycle.
  assign rx_ready = !rst && (state == LEN || state == DATA || state == CSUM) &&
                    (!mem_we || mem_ready);
  assign acc      = rx_valid && rx_ready;
  assign byte_vld = acc && (state == DATA);
  assign mem_wem  = mem_we ? BOOT_WEM_FULL : 4'h0;

  assign last_len_byte = (len_cnt == 2'(BOOT_LEN_BYTES - 1));
  assign n_next        = {rx_data, len_p0};

  cirno9_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_vld  (byte_vld),
    .byte_data (rx_data),
    .word_vld  (word_vld),
    .word_data (word_data),
    .sum       (sum)
  );

  // Length header shift register: the first three bytes wait here until the
  // fourth arrives and the whole count is evaluated.
  always_ff @(posedge clk) begin
    if (acc && state == LEN) len_p0 <= {rx_data, len_p0[23:8]};
  end

  // Loader FSM, word address counter and write handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN;
      len_cnt   <= 2'd0;
      word_idx  <= '0;
      len_last  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // A newly completed word takes priority so back-to-back writes never
      // open a gap; otherwise the write retires when the SRAM accepts it.
      if (word_vld) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_idx[ADDR_W-1:0];
        mem_wdata <= word_data;
        word_idx  <= word_idx + 1'b1;
      end else if (mem_ready) begin
        mem_we <= 1'b0;
      end

      case (state)
        LEN: begin
          if (acc) begin
            len_cnt <= len_cnt + 2'd1;
            if (last_len_byte) begin
              if ({1'b0, n_next} > CAP_WORDS) begin
                state    <= ERR;
                load_err <= 1'b1;
              end else if (n_next == 32'd0) begin
                state <= CSUM;
              end else begin
                // N-1 fits in ADDR_W+1 bits since 1 <= N <= 2^ADDR_W.
                state    <= DATA;
                len_last <= n_next[ADDR_W:0] - 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (word_vld && word_idx == len_last) state <= CSUM;
        end
        CSUM: begin
          if (acc) begin
            if (rx_data == sum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
